// File: rtl/decrypter.sv
// Rotating-key XOR decrypter with four-phase req/ack handshakes on both sides; one word in flight.
// Registered outputs; upstream stalls with reqIn high until the downstream handshake fully releases.
module decrypter #(
  parameter int DATA_WIDTH = 32,
  parameter int ROT_WIDTH  = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [ROT_WIDTH-1:0]  rot_offset,
  input  logic                  reqIn,
  output logic                  ackIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  reqOut,
  input  logic                  ackOut,
  output logic [2:0]            state,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  no_key_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READY   = 3'd1,
    ACK     = 3'd2,
    SEND    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   key_reg, key_d;
  logic [DATA_WIDTH-1:0]   data_reg, data_d;
  logic [ROT_WIDTH-1:0]    off_reg, off_d;
  logic                    ack_d, req_d, err_d;
  logic [DATA_WIDTH-1:0]   dout_d;
  logic [CNT_WIDTH-1:0]    cnt_d;

  // Doubling the key turns the rotate into one shift; n stays below the width.
  function automatic logic [DATA_WIDTH-1:0] rotl(input logic [DATA_WIDTH-1:0] k,
                                                  input logic [ROT_WIDTH-1:0]  off);
    logic [2*DATA_WIDTH-1:0] dbl;
    logic [31:0]             n;
    n   = 32'(off) % 32'(DATA_WIDTH);
    dbl = {k, k} << n;
    return dbl[2*DATA_WIDTH-1:DATA_WIDTH];
  endfunction

  always_comb begin
    state_d = state_q;
    key_d   = key_reg;
    data_d  = data_reg;
    off_d   = off_reg;
    ack_d   = ackIn;
    req_d   = reqOut;
    err_d   = no_key_err;
    dout_d  = dataOut;
    cnt_d   = word_count;
    case (state_q)
      IDLE: begin
        if (prog) begin
          key_d   = dataIn;
          err_d   = 1'b0;
          state_d = READY;
        end else if (reqIn) begin
          err_d = 1'b1;
        end
      end
      READY: begin
        if (prog) begin
          key_d = dataIn;
        end else if (reqIn) begin
          data_d  = dataIn;
          off_d   = rot_offset;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!reqIn) begin
          ack_d   = 1'b0;
          dout_d  = data_reg ^ rotl(key_reg, off_reg);
          req_d   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ackOut) begin
          req_d   = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!ackOut) begin
          cnt_d   = word_count + CNT_WIDTH'(1);
          state_d = READY;
        end
      end
      default: begin
        ack_d   = 1'b0;
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      key_reg    <= '0;
      data_reg   <= '0;
      off_reg    <= '0;
      ackIn      <= 1'b0;
      reqOut     <= 1'b0;
      dataOut    <= '0;
      word_count <= '0;
      no_key_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_reg    <= key_d;
      data_reg   <= data_d;
      off_reg    <= off_d;
      ackIn      <= ack_d;
      reqOut     <= req_d;
      dataOut    <= dout_d;
      word_count <= cnt_d;
      no_key_err <= err_d;
    end
  end

  assign state = state_q;

endmodule
